// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the ram_ctrl front-end: FSM encoding and wait-counter sizing.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int MAX_WAIT = 16;
    localparam int CNT_W    = $clog2(MAX_WAIT);

endpackage

// File: rtl/ram_ctrl.sv
// Valid/ready command front-end for a level-sensitive single-port RAM.
// Address and write data are only updated while chip select is low.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int WR_CYCLES  = 1,
    parameter int RD_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  wr_done,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    if (WR_CYCLES < 1 || WR_CYCLES > MAX_WAIT) begin : g_bad_wr_cycles
        $error("ram_ctrl: WR_CYCLES=%0d outside 1..%0d", WR_CYCLES, MAX_WAIT);
    end
    if (RD_CYCLES < 1 || RD_CYCLES > MAX_WAIT) begin : g_bad_rd_cycles
        $error("ram_ctrl: RD_CYCLES=%0d outside 1..%0d", RD_CYCLES, MAX_WAIT);
    end

    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  accept;

    logic                  cs_d, we_d, oe_d, wr_done_d, busy_d, rsp_valid_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d, rsp_rdata_d;

    assign cmd_ready = (state == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            wr_done   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ram_cs    <= cs_d;
            ram_we    <= we_d;
            ram_oe    <= oe_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            wr_done   <= wr_done_d;
            busy      <= busy_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = cmd_we ? WR : RD;
                    cnt_nxt   = cmd_we ? WR_LOAD : RD_LOAD;
                end
            end
            WR: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            RD: begin
                if (cnt == '0) state_nxt = RESP;
                else           cnt_nxt   = cnt - 1'b1;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state, so they line up exactly
    // with the cycles the FSM spends in WR or RD.
    always_comb begin
        cs_d        = (state_nxt == WR) || (state_nxt == RD);
        we_d        = (state_nxt == WR);
        oe_d        = (state_nxt == RD);
        wr_done_d   = (state_nxt == WR) && (cnt_nxt == '0);
        busy_d      = (state_nxt != IDLE);
        addr_d      = ram_addr;
        wdata_d     = ram_wdata;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        if (accept) begin
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
        end
        if (state == RD && cnt == '0) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = ram_rdata;
        end
        if (state == RESP && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic against an array model of memory contents.
module tb_ram_ctrl;

    localparam int WR_CYCLES = 1;
    localparam int RD_CYCLES = 2;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic       rst, cmd_valid, cmd_ready, cmd_we, rsp_valid, rsp_ready;
    logic       wr_done, busy, ram_cs, ram_we, ram_oe;
    logic [7:0] cmd_addr, cmd_wdata, rsp_rdata, ram_addr, ram_wdata, ram_rdata;

    // RD_CYCLES=4 instance signals for the reset-mid-read sequence
    logic       rst4, cmd_valid4, cmd_ready4, cmd_we4, rsp_valid4, rsp_ready4;
    logic       wr_done4, busy4, ram_cs4, ram_we4, ram_oe4;
    logic [7:0] cmd_addr4, cmd_wdata4, rsp_rdata4, ram_addr4, ram_wdata4, ram_rdata4;

    ram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WR_CYCLES(WR_CYCLES), .RD_CYCLES(RD_CYCLES)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .wr_done(wr_done), .busy(busy), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
    );

    ram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WR_CYCLES(1), .RD_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst4), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_we(cmd_we4),
        .cmd_addr(cmd_addr4), .cmd_wdata(cmd_wdata4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_rdata(rsp_rdata4), .wr_done(wr_done4), .busy(busy4), .ram_addr(ram_addr4),
        .ram_wdata(ram_wdata4), .ram_rdata(ram_rdata4), .ram_cs(ram_cs4), .ram_we(ram_we4), .ram_oe(ram_oe4)
    );

    // RAM model: level-sensitive write, sampled mid-cycle while strobes are stable
    logic [7:0] ram_mem [256];
    always @(negedge clk) if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_wdata;
    assign ram_rdata  = (ram_cs && ram_oe) ? ram_mem[ram_addr] : 8'h00;
    assign ram_rdata4 = (ram_cs4 && ram_oe4) ? ~ram_addr4 : 8'h00;

    logic [7:0] model_mem [256];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Strobe invariants and address/data stability while cs is high
    logic       prev_cs;
    logic [7:0] prev_addr, prev_wdata;
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we || ram_oe) check("strobe_without_cs", ram_cs, 1);
            if (ram_cs) check("we_oe_exclusive", ram_we & ram_oe, 0);
            if (ram_cs && prev_cs) begin
                check("addr_stable", ram_addr, prev_addr);
                check("wdata_stable", ram_wdata, prev_wdata);
            end
        end
        prev_cs    <= ram_cs;
        prev_addr  <= ram_addr;
        prev_wdata <= ram_wdata;
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!cmd_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check({name, "_ready_timeout"}, 0, 1);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        wait_ready("wr");
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = addr; cmd_wdata = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= WR_CYCLES; k++) begin
            check("wr_cs", ram_cs, 1);
            check("wr_we", ram_we, 1);
            check("wr_oe", ram_oe, 0);
            check("wr_addr", ram_addr, addr);
            check("wr_wdata", ram_wdata, data);
            check("wr_done", wr_done, (k == WR_CYCLES));
            check("wr_busy", busy, 1);
            check("wr_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        check("wr_end_cs", ram_cs, 0);
        check("wr_end_done", wr_done, 0);
        check("wr_end_ready", cmd_ready, 1);
        model_mem[addr] = data;
    endtask

    task automatic do_read(input logic [7:0] addr, input int delay, input bit noise,
                           input logic [7:0] exp);
        wait_ready("rd");
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = addr; cmd_wdata = 8'($urandom);
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        for (int k = 1; k <= RD_CYCLES; k++) begin
            check("rd_cs", ram_cs, 1);
            check("rd_oe", ram_oe, 1);
            check("rd_we", ram_we, 0);
            check("rd_addr", ram_addr, addr);
            check("rd_early_valid", rsp_valid, 0);
            @(negedge clk);
        end
        check("rd_valid", rsp_valid, 1);
        check("rd_data", rsp_rdata, exp);
        check("rd_resp_cs", ram_cs, 0);
        check("rd_resp_ready", cmd_ready, 0);
        if (delay == 0) rsp_ready = 1'b1;
        else if (noise) begin
            cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = ~addr; cmd_wdata = ~exp;
        end
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_data", rsp_rdata, exp);
            check("bp_strobes", {ram_cs, ram_we, ram_oe}, 0);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_addr_kept", ram_addr, addr);
            if (d == delay - 1) begin
                rsp_ready = 1'b1;
                cmd_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("rd_valid_drop", rsp_valid, 0);
        check("rd_ready_back", cmd_ready, 1);
        check("rd_data_kept", rsp_rdata, exp);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         delay;
        bit         noise;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic apply_vec(input int i);
        if (vecs[i].we) do_write(vecs[i].addr, vecs[i].wdata);
        else            do_read(vecs[i].addr, vecs[i].delay, vecs[i].noise, vecs[i].exp);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h3C, 8'hA5, 0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 8'h10, 8'h5A, 0, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 8'h10, 8'h00, 0, 1'b0, 8'h5A};
        vecs[3] = '{1'b0, 8'h10, 8'h00, 5, 1'b1, 8'h5A};
        vecs[4] = '{1'b0, 8'h3C, 8'h00, 1, 1'b0, 8'hA5};
        vecs[5] = '{1'b0, 8'h00, 8'h00, 0, 1'b0, 8'h11};
        vecs[6] = '{1'b0, 8'h01, 8'h00, 2, 1'b0, 8'h22};
        vecs[7] = '{1'b0, 8'h02, 8'h00, 0, 1'b0, 8'h33};
        vecs[8] = '{1'b0, 8'h03, 8'h00, 1, 1'b0, 8'h44};

        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        rst4 = 1'b1; cmd_valid4 = 1'b0; cmd_we4 = 1'b0; cmd_addr4 = '0; cmd_wdata4 = '0; rsp_ready4 = 1'b0;

        // Reset then idle
        repeat (3) begin
            @(negedge clk);
            check("rst_strobes", {ram_cs, ram_we, ram_oe}, 0);
            check("rst_busy", busy, 0);
            check("rst_cmd_ready", cmd_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_addr", ram_addr, 0);

        for (int i = 0; i < 5; i++) apply_vec(i);

        // Back-to-back writes with cmd_valid held high throughout
        begin
            int cyc = 0, last = -1, n = 0;
            cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h00; cmd_wdata = 8'h11;
            while (n < 4 && cyc < 100) begin
                if (cmd_ready) begin
                    check("b2b_cs_gap", ram_cs, 0);
                    if (last >= 0) check("b2b_spacing", cyc - last, WR_CYCLES + 1);
                    last = cyc;
                    model_mem[cmd_addr] = cmd_wdata;
                    n++;
                end
                @(negedge clk);
                cyc++;
                if (last == cyc - 1) begin
                    cmd_addr  = 8'(n);
                    cmd_wdata = 8'((n + 1) * 8'h11);
                end
            end
            cmd_valid = 1'b0;
            check("b2b_count", n, 4);
            repeat (WR_CYCLES) @(negedge clk);
        end

        for (int i = 5; i < 9; i++) apply_vec(i);

        // Randomized traffic against the array model
        for (int a = 8'h20; a < 8'h30; a++) do_write(8'(a), 8'($urandom));
        for (int t = 0; t < 150; t++) begin
            logic [7:0] a = 8'(8'h20 + $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom));
            else do_read(a, int'($urandom_range(0, 3)), 1'b0, model_mem[a]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset mid-read on the RD_CYCLES=4 instance
        repeat (2) @(negedge clk);
        rst4 = 1'b0;
        @(negedge clk);
        check("r4_ready", cmd_ready4, 1);
        cmd_valid4 = 1'b1; cmd_addr4 = 8'h22;
        @(negedge clk);
        cmd_valid4 = 1'b0;
        check("r4_cs_c1", ram_cs4, 1);
        @(negedge clk);
        check("r4_oe_c2", ram_oe4, 1);
        rst4 = 1'b1;
        @(negedge clk);
        check("r4_rst_strobes", {ram_cs4, ram_we4, ram_oe4}, 0);
        check("r4_rst_busy", busy4, 0);
        check("r4_rst_valid", rsp_valid4, 0);
        check("r4_rst_done", wr_done4, 0);
        check("r4_rst_ready", cmd_ready4, 0);
        check("r4_rst_addr", ram_addr4, 0);
        check("r4_rst_wdata", ram_wdata4, 0);
        rst4 = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("r4_no_valid", rsp_valid4, 0);
            check("r4_no_cs", ram_cs4, 0);
        end
        check("r4_ready_again", cmd_ready4, 1);
        cmd_valid4 = 1'b1; cmd_addr4 = 8'h5E;
        @(negedge clk);
        cmd_valid4 = 1'b0; rsp_ready4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("r4_rd_cs", ram_cs4 & ram_oe4, 1);
            check("r4_rd_valid_low", rsp_valid4, 0);
            @(negedge clk);
        end
        check("r4_rsp_valid", rsp_valid4, 1);
        check("r4_rsp_data", rsp_rdata4, 8'hA1);
        @(negedge clk);
        check("r4_rsp_drop", rsp_valid4, 0);
        check("r4_ready_end", cmd_ready4, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Synchronous front-end controller sitting directly upstream of the single-port async-write RAM model.
- Converts a valid/ready command stream (read or write, one word each) into correctly sequenced RAM strobes: cs, we, oe, address and write data.
- Returns read data on a valid/ready response channel.
- Guarantees address/data stability while write strobes are active, because the RAM writes on level, not on edge.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- WR_CYCLES, 1, cycles cs+we held per write; legal range 1..16.
- RD_CYCLES, 2, cycles cs+oe held per read before sampling; legal range 1..16.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_we  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts read data.
- rsp_rdata  out  DATA_WIDTH  captured read data.
- wr_done  out  1  one-cycle pulse on the last write-strobe cycle.
- busy  out  1  state != IDLE.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data (tri-state bus resolved externally).
- ram_cs  out  1  chip select.
- ram_we  out  1  write enable.
- ram_oe  out  1  output enable.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Registered outputs: all outputs except cmd_ready are registered. cmd_ready = (state==IDLE) && !rst.
- Reset values:
  - State: IDLE.
  - Zero: ram_cs, ram_we, ram_oe, ram_addr, ram_wdata, rsp_valid, rsp_rdata, wr_done, busy.
  - Cycle counter: 0.
- FSM states: IDLE, WR, RD, RESP.
- IDLE:
  - Strobes low.
  - On cmd_valid&&cmd_ready: latch cmd_addr into ram_addr and cmd_wdata into ram_wdata; load counter with (WR_CYCLES-1) or (RD_CYCLES-1).
  - Next state: WR if cmd_we, else RD.
  - ram_addr and ram_wdata change only in IDLE, i.e. only while ram_cs=0.
- WR:
  - ram_cs=1, ram_we=1, ram_oe=0.
  - Counter decrements each cycle.
  - wr_done=1 in the cycle where counter==0.
  - Next state: IDLE.
- RD:
  - ram_cs=1, ram_oe=1, ram_we=0.
  - At the edge ending the cycle with counter==0: rsp_rdata<=ram_rdata, rsp_valid<=1, all strobes drop.
  - Next state: RESP.
- RESP:
  - Strobes low; rsp_valid=1 and rsp_rdata held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, go IDLE.
  - rsp_rdata retains its value after the handshake.
- Latency, write: accept at edge N; strobes active cycles N+1..N+WR_CYCLES; cmd_ready high again in cycle N+WR_CYCLES+1.
- Latency, read: accept at edge N; strobes active cycles N+1..N+RD_CYCLES; rsp_valid high from cycle N+RD_CYCLES+1.
- Back-to-back commands: at least one cs-low cycle (IDLE) separates consecutive operations. Max throughput is one write per WR_CYCLES+1 cycles.
- Invariants:
  - ram_we && ram_oe never both 1.
  - ram_we/ram_oe never 1 without ram_cs.
  - cmd_valid while !cmd_ready: command is ignored (not latched); the producer must hold it.
  - rsp_ready while !rsp_valid: no effect.
- Reset mid-operation: at the next edge, state goes to IDLE, all strobes go low, any pending response is discarded (rsp_valid=0), and no wr_done pulse is emitted. A partial write to the RAM may already have occurred; this is acceptable.
- Counter width: $clog2(16) = 4 bits. Values outside 1..16 for WR_CYCLES or RD_CYCLES are flagged by an elaboration-time check.

Decomposition:
- Shared package/include ram_ctrl_pkg:
  - State encoding localparams (IDLE=2'd0, WR=2'd1, RD=2'd2, RESP=2'd3).
  - MAX_WAIT=16 and counter width constant.
- No sub-module. The single wait counter is inline in ram_ctrl.
- The bench instantiates ram_ctrl plus the RAM model back-to-back.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 3 cycles.
  - Required: all strobes 0, cmd_ready=1 the cycle after rst falls, busy=0.
- Single write, WR_CYCLES=1:
  - Stimulus: cmd_we=1, addr=0x3C, wdata=0xA5.
  - Required: ram_cs=ram_we=1 for exactly 1 cycle with addr=0x3C and wdata=0xA5 stable; wr_done pulses in that cycle; cmd_ready returns the next cycle.
- Write then read back, RD_CYCLES=2:
  - Stimulus: write 0x5A to 0x10, then read 0x10 with rsp_ready=1.
  - Required: cs/oe high 2 cycles; rsp_valid=1 with rsp_rdata=0x5A on the 3rd cycle after accept; rsp_valid lasts 1 cycle.
- Response backpressure:
  - Stimulus: read 0x10 with rsp_ready=0 for 5 cycles, then 1.
  - Required: rsp_valid and rsp_rdata=0x5A held for all 6 cycles; cmd_ready=0 throughout; strobes low during RESP.
- Back-to-back writes:
  - Stimulus: cmd_valid held continuously for writes to 0x00..0x03 with data 0x11..0x44.
  - Required: a cs-low cycle between each write; subsequent reads return 0x11, 0x22, 0x33, 0x44.
- Reset mid-read, RD_CYCLES=4:
  - Stimulus: assert rst in the 2nd RD cycle.
  - Required: strobes 0 at the next edge; rsp_valid never asserts; the next command is accepted normally after reset.
